// File: rtl/core_pkg.sv
// core_pkg: shared definitions for the multi-cycle RV32 sequencer.
// Contents: FSM state encoding, the opcode/funct3 constants used by decode,
// the EBREAK encoding and the default reset PC.
package core_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [6:0]  OP_IMM           = 7'b0010011;
    localparam logic [2:0]  F3_ADDI          = 3'b000;
    localparam logic [31:0] EBREAK           = 32'h00100073;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h80000000;

endpackage

// File: rtl/imm_decode.sv
// imm_decode: I-type immediate extraction and sign extension.
// Ports:
//   imm_field in 12 : instruction bits [31:20]
//   imm_i     out 32: sign-extended immediate
// Purely combinational; shared by every I-type instruction.
module imm_decode (
    input  logic [11:0] imm_field,
    output logic [31:0] imm_i
);

    assign imm_i = {{20{imm_field[11]}}, imm_field};

endmodule

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle control unit for the RV32 datapath.
// Sequences FETCH -> DECODE -> EXEC -> WB for addi, halts on ebreak,
// unsupported instructions or a fetch that sees no imem_valid for TIMEOUT
// cycles.
// Ports:
//   clk, reset               : clock, synchronous active-high reset
//   imem_req/addr/valid/rdata: instruction fetch handshake
//   rf_raddr/rdata           : register-file read port (rs1)
//   rf_waddr/wdata/wen       : register-file write port (rd)
//   pc, instret              : program counter, retired-instruction count
//   halted, illegal, bus_err : sticky halt status
module core_sequencer
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [4:0]  rf_raddr,
    input  logic [31:0] rf_rdata,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        rf_wen,
    output logic [31:0] pc,
    output logic [31:0] instret,
    output logic        halted,
    output logic        illegal,
    output logic        bus_err
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic [31:0] ir;
    logic [31:0] result;
    logic [7:0]  wait_cnt;
    logic [31:0] imm_i;

    imm_decode u_imm_decode (
        .imm_field (ir[31:20]),
        .imm_i     (imm_i)
    );

    // NOTE: these strobes depend only on registers (state, ir), never on
    // inputs, so they cannot glitch or form combinational paths through
    // the memory or register file.
    assign imem_req  = (state == S_FETCH);
    assign rf_wen    = (state == S_WB) && (ir[11:7] != 5'd0);

    assign imem_addr = pc;
    assign rf_raddr  = ir[19:15];
    assign rf_waddr  = ir[11:7];
    assign rf_wdata  = result;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_FETCH;
            pc       <= RESET_PC;
            ir       <= '0;
            result   <= '0;
            instret  <= '0;
            wait_cnt <= '0;
            halted   <= 1'b0;
            illegal  <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch
            // reads the pre-edge value of state and counters.
            case (state)
                S_FETCH: begin
                    if (imem_valid) begin
                        ir       <= imem_rdata;
                        wait_cnt <= '0;
                        state    <= S_DECODE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        // wait_cnt counts completed empty cycles; this is
                        // the TIMEOUT-th one.
                        if (wait_cnt == TIMEOUT_LAST) begin
                            bus_err <= 1'b1;
                            halted  <= 1'b1;
                            state   <= S_HALT;
                        end
                    end
                end
                S_DECODE: begin
                    if (ir[6:0] == OP_IMM && ir[14:12] == F3_ADDI) begin
                        state <= S_EXEC;
                    end else if (ir == EBREAK) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else begin
                        illegal <= 1'b1;
                        halted  <= 1'b1;
                        state   <= S_HALT;
                    end
                end
                S_EXEC: begin
                    result <= rf_rdata + imm_i;
                    state  <= S_WB;
                end
                S_WB: begin
                    pc      <= pc + 32'd4;
                    instret <= instret + 32'd1;
                    state   <= S_FETCH;
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    halted <= 1'b1;
                    state  <= S_HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: directed bench for core_sequencer with a register-file
// model, a write-back scoreboard and direct status checks.
module tb_core_sequencer;

    localparam logic [31:0] RPC = 32'h80000000;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] val;
    } wb_t;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        rf_wen;
    logic [31:0] pc;
    logic [31:0] instret;
    logic        halted;
    logic        illegal;
    logic        bus_err;

    int  passed = 0;
    int  total  = 0;
    wb_t exp_q[$];
    logic [31:0] regs [32];

    core_sequencer #(.RESET_PC(RPC), .TIMEOUT(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_rdata (imem_rdata),
        .rf_raddr   (rf_raddr),
        .rf_rdata   (rf_rdata),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .rf_wen     (rf_wen),
        .pc         (pc),
        .instret    (instret),
        .halted     (halted),
        .illegal    (illegal),
        .bus_err    (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: x0 reads zero, writes land on the rising edge.
    assign rf_rdata = (rf_raddr == 5'd0) ? 32'd0 : regs[rf_raddr];
    always @(posedge clk) begin
        if (rf_wen && rf_waddr != 5'd0) regs[rf_waddr] <= rf_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Scoreboard monitor: every write-back strobe must match the oldest
    // expected write; a strobe with nothing expected is an error.
    always @(negedge clk) begin
        if (rf_wen === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rf_wen", {27'd0, rf_waddr}, 32'hffffffff);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                check("wb_waddr", {27'd0, rf_waddr}, {27'd0, e.rd});
                check("wb_wdata", rf_wdata, e.val);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        imem_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Starts at a negedge in the first FETCH cycle. Presents instr after
    // `waits` empty cycles and returns the number of edges until the PC
    // moves or the core halts.
    task automatic issue(input logic [31:0] instr, input int waits, output int cycles);
        logic [31:0] old_pc;
        old_pc = pc;
        cycles = 0;
        while (1) begin
            imem_valid = (cycles == waits);
            imem_rdata = instr;
            @(negedge clk);
            imem_valid = 1'b0;
            cycles++;
            if (pc !== old_pc || halted === 1'b1) break;
            if (cycles > 64) begin
                check("issue_timeout", 32'(cycles), 32'(4 + waits));
                break;
            end
        end
    endtask

    initial begin
        int cyc;
        int req_cnt;
        logic [31:0] hold_pc;

        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        reset      = 1'b1;
        imem_valid = 1'b0;
        imem_rdata = 32'd0;

        // Reset state, observed while reset is still asserted.
        @(negedge clk);
        @(negedge clk);
        check("rst_pc", pc, RPC);
        check("rst_instret", instret, 32'd0);
        check("rst_flags", {29'd0, halted, illegal, bus_err}, 32'd0);
        check("rst_rf_wen", {31'd0, rf_wen}, 32'd0);
        reset = 1'b0;
        check("first_req", {31'd0, imem_req}, 32'd1);
        check("first_addr", imem_addr, RPC);

        // addi x1,x0,5 with zero wait states.
        exp_q.push_back('{5'd1, 32'd5});
        issue(32'h00500093, 0, cyc);
        check("addi1_cycles", 32'(cyc), 32'd4);
        check("addi1_pc", pc, 32'h80000004);
        check("addi1_instret", instret, 32'd1);

        // addi x2,x1,-1 with three wait states.
        exp_q.push_back('{5'd2, 32'd4});
        issue(32'hfff08113, 3, cyc);
        check("addi2_cycles", 32'(cyc), 32'd7);
        check("addi2_pc", pc, 32'h80000008);
        check("addi2_instret", instret, 32'd2);

        // addi x0,x0,1: retires but never writes.
        issue(32'h00100013, 0, cyc);
        check("addi_x0_cycles", 32'(cyc), 32'd4);
        check("addi_x0_pc", pc, 32'h8000000c);
        check("addi_x0_instret", instret, 32'd3);

        // Reset during the 2nd wait cycle of the third instruction, with a
        // stale response (ebreak) arriving in that same cycle.
        do_reset();
        exp_q.push_back('{5'd1, 32'd5});
        issue(32'h00500093, 0, cyc);
        exp_q.push_back('{5'd2, 32'd4});
        issue(32'hfff08113, 0, cyc);
        check("pre_rst_pc", pc, 32'h80000008);
        @(negedge clk);
        reset      = 1'b1;
        imem_valid = 1'b1;
        imem_rdata = 32'h00100073;
        @(negedge clk);
        reset      = 1'b0;
        imem_valid = 1'b0;
        check("midrst_pc", pc, RPC);
        check("midrst_instret", instret, 32'd0);
        check("midrst_req", {31'd0, imem_req}, 32'd1);
        @(negedge clk);
        check("midrst_still_fetch", {31'd0, imem_req}, 32'd1);
        check("midrst_not_halted", {31'd0, halted}, 32'd0);
        // addi x3,x0,7 must be the instruction that executes.
        exp_q.push_back('{5'd3, 32'd7});
        issue(32'h00700193, 0, cyc);
        check("post_rst_cycles", 32'(cyc), 32'd4);
        check("post_rst_pc", pc, 32'h80000004);
        check("post_rst_instret", instret, 32'd1);

        // ebreak: clean halt, then 20 cycles of stray responses ignored.
        issue(32'h00100073, 0, cyc);
        check("ebreak_cycles", 32'(cyc), 32'd2);
        check("ebreak_flags", {29'd0, halted, illegal, bus_err}, 32'b100);
        hold_pc = pc;
        req_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            imem_valid = 1'b1;
            imem_rdata = 32'h00500093;
            @(negedge clk);
            if (imem_req === 1'b1) req_cnt++;
        end
        imem_valid = 1'b0;
        check("halt_no_req", 32'(req_cnt), 32'd0);
        check("halt_pc_hold", hold_pc, 32'h80000004);
        check("halt_pc_now", pc, 32'h80000004);
        check("halt_instret", instret, 32'd1);

        // Unsupported instruction (add x0,x0,x0).
        do_reset();
        issue(32'h00000033, 0, cyc);
        check("illegal_flags", {29'd0, halted, illegal, bus_err}, 32'b110);
        check("illegal_pc", pc, RPC);

        // Fetch timeout: no response for 16 FETCH cycles.
        do_reset();
        repeat (15) @(negedge clk);
        check("timeout_15_not_halted", {31'd0, halted}, 32'd0);
        @(negedge clk);
        check("timeout_flags", {29'd0, halted, illegal, bus_err}, 32'b101);
        check("timeout_req", {31'd0, imem_req}, 32'd0);

        @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
